// File: rtl/ibuffer_warp_if.sv
// Decode/issue side of the per-warp instruction buffer, bundled as one interface.
// master: decode lanes + issue arbiter (drive writes, flushes, grants).
// slave : the instruction buffer itself.
interface ibuffer_warp_if #(
  parameter int NUM_WARPS = 8,
  parameter int ENTRY_W   = 96
);
  localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  logic [NUM_WARPS-1:0] Valid_ID0_IB;
  logic [ENTRY_W-1:0]   Entry_ID0_IB;
  logic [NUM_WARPS-1:0] Valid_ID1_IB;
  logic [ENTRY_W-1:0]   Entry_ID1_IB;
  logic [NUM_WARPS-1:0] Flush_IB;
  logic [NUM_WARPS-1:0] Grant_Issue_IB;
  logic [NUM_WARPS-1:0] Full_IB_IF;
  logic [NUM_WARPS-1:0] AlmostFull_IB_IF;
  logic [NUM_WARPS-1:0] HeadValid_IB_Issue;
  logic                 Issue_Valid_IB;
  logic [WID_W-1:0]     Issue_WarpID_IB;
  logic [ENTRY_W-1:0]   Issue_Entry_IB;
  logic                 Err_IB;

  modport master (
    output Valid_ID0_IB, Entry_ID0_IB, Valid_ID1_IB, Entry_ID1_IB,
           Flush_IB, Grant_Issue_IB,
    input  Full_IB_IF, AlmostFull_IB_IF, HeadValid_IB_Issue,
           Issue_Valid_IB, Issue_WarpID_IB, Issue_Entry_IB, Err_IB
  );

  modport slave (
    input  Valid_ID0_IB, Entry_ID0_IB, Valid_ID1_IB, Entry_ID1_IB,
           Flush_IB, Grant_Issue_IB,
    output Full_IB_IF, AlmostFull_IB_IF, HeadValid_IB_Issue,
           Issue_Valid_IB, Issue_WarpID_IB, Issue_Entry_IB, Err_IB
  );
endinterface

// File: rtl/ibuffer_warp.sv
// Per-warp instruction buffer: one circular FIFO per warp fed by two decode
// lanes (lane 0 older), popped by a one-hot issue grant into registered issue
// outputs, with per-warp flush on redirect.
// Optional macro IBUF_ERR_EN: when defined, Err_IB is a sticky protocol-error
// flag (dropped write, empty pop, multi-hot grant); otherwise Err_IB is tied 0.
module ibuffer_warp #(
  parameter int NUM_WARPS = 8,
  parameter int DEPTH     = 4,
  parameter int ENTRY_W   = 96
) (
  input logic           clk,
  input logic           rst_n,
  ibuffer_warp_if.slave ib
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  typedef logic [PTR_W-1:0]   ptr_t;
  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [ENTRY_W-1:0] entry_t;

  // Per-warp FIFO state and its next-state values.
  ptr_t rp_q [NUM_WARPS];
  ptr_t wp_q [NUM_WARPS];
  cnt_t cnt_q[NUM_WARPS];
  ptr_t rp_d [NUM_WARPS];
  ptr_t wp_d [NUM_WARPS];
  cnt_t cnt_d[NUM_WARPS];

  entry_t mem [NUM_WARPS][DEPTH];

  // Per-warp decisions for this cycle.
  cnt_t                 free_slots[NUM_WARPS];
  ptr_t                 slot1     [NUM_WARPS];
  logic [NUM_WARPS-1:0] pop;
  logic [NUM_WARPS-1:0] acc0;
  logic [NUM_WARPS-1:0] acc1;

  // Grant resolution.
  logic [NUM_WARPS-1:0] gnt_oh;
  logic [WID_W-1:0]     gnt_idx;
  logic                 pop_any;

  // Issue registers.
  logic                 issue_valid_q;
  logic [WID_W-1:0]     issue_wid_q;
  entry_t               issue_entry_q;

  // Reduce the grant to its lowest set bit and encode it as a warp index.
  always_comb begin
    gnt_oh  = ib.Grant_Issue_IB & (~ib.Grant_Issue_IB + NUM_WARPS'(1));
    gnt_idx = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (gnt_oh[w]) gnt_idx = WID_W'(w);
    end
    pop_any = |pop;
  end

  // Per-warp accept/pop decisions and next pointers; flush wins over all else.
  // Free space is measured before the pop, so a slot freed this cycle is not reused.
  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      free_slots[w] = cnt_t'(DEPTH) - cnt_q[w];
      pop[w]   = gnt_oh[w] & ~ib.Flush_IB[w] & (cnt_q[w] != '0);
      acc0[w]  = ib.Valid_ID0_IB[w] & ~ib.Flush_IB[w] & (free_slots[w] != '0);
      acc1[w]  = ib.Valid_ID1_IB[w] & ~ib.Flush_IB[w] & (free_slots[w] > cnt_t'(acc0[w]));
      slot1[w] = wp_q[w] + ptr_t'(acc0[w]);
      rp_d[w]  = rp_q[w] + ptr_t'(pop[w]);
      wp_d[w]  = wp_q[w] + ptr_t'(acc0[w]) + ptr_t'(acc1[w]);
      cnt_d[w] = cnt_q[w] - cnt_t'(pop[w]) + cnt_t'(acc0[w]) + cnt_t'(acc1[w]);
      if (ib.Flush_IB[w]) begin
        rp_d[w]  = '0;
        wp_d[w]  = '0;
        cnt_d[w] = '0;
      end
    end
  end

  // Pointer and count registers.
  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        rp_q[w]  <= '0;
        wp_q[w]  <= '0;
        cnt_q[w] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        rp_q[w]  <= rp_d[w];
        wp_q[w]  <= wp_d[w];
        cnt_q[w] <= cnt_d[w];
      end
    end
  end

  // Entry storage: lane 0 lands at wp, lane 1 right behind it.
  // NOTE: storage is deliberately not reset; cnt gates every read, and a reset would force flops instead of RAM.
  always_ff @(posedge clk) begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (acc0[w]) mem[w][wp_q[w]]  <= ib.Entry_ID0_IB;
      if (acc1[w]) mem[w][slot1[w]] <= ib.Entry_ID1_IB;
    end
  end

  // Issue registers: one-cycle pulse carrying the popped head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_q <= 1'b0;
      issue_wid_q   <= '0;
      issue_entry_q <= '0;
    end else begin
      issue_valid_q <= pop_any;
      if (pop_any) begin
        issue_wid_q   <= gnt_idx;
        issue_entry_q <= mem[gnt_idx][rp_q[gnt_idx]];
      end
    end
  end

  // Status toward fetch and issue, straight from the registered counts.
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      ib.Full_IB_IF[w]         = (cnt_q[w] == cnt_t'(DEPTH));
      ib.AlmostFull_IB_IF[w]   = (cnt_q[w] >= cnt_t'(DEPTH - 2));
      ib.HeadValid_IB_Issue[w] = (cnt_q[w] != '0);
    end
  end

  assign ib.Issue_Valid_IB  = issue_valid_q;
  assign ib.Issue_WarpID_IB = issue_wid_q;
  assign ib.Issue_Entry_IB  = issue_entry_q;

`ifdef IBUF_ERR_EN
  logic err_q;
  logic err_set;
  logic multi_hot;
  logic drop_any;
  logic empty_pop;

  // Error sources: dropped write on a non-flushed warp, grant to an empty
  // non-flushed warp, or more than one grant bit set.
  always_comb begin
    multi_hot = |(ib.Grant_Issue_IB & (ib.Grant_Issue_IB - NUM_WARPS'(1)));
    drop_any  = |(((ib.Valid_ID0_IB & ~acc0) | (ib.Valid_ID1_IB & ~acc1)) & ~ib.Flush_IB);
    empty_pop = |(gnt_oh & ~ib.Flush_IB & ~pop);
    err_set   = multi_hot | drop_any | empty_pop;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_q | err_set;
  end

  assign ib.Err_IB = err_q;
`else
  assign ib.Err_IB = 1'b0;
`endif
endmodule
